// File: rtl/onehot_req_serializer.sv
// onehot_req_serializer: sticky request capture feeding a one-hot valid/ready grant stage
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req         request strobes, OR-ed into the sticky pending vector every edge
//   out_onehot  registered grant, zero or exactly one-hot, zero when out_valid=0
//   out_valid   out_onehot holds a grant
//   out_ready   downstream takes the grant on this edge when out_valid=1
//   pending     requests captured but not yet moved into the output stage
//   pending_cnt popcount of pending
//   overflow    one-cycle pulse when a request hits a line still pending
module onehot_req_serializer #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  out_onehot,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  pending,
    output logic [CW-1:0] pending_cnt,
    output logic          overflow
);
    logic [N-1:0]  onehot_q, onehot_d, pending_q, pending_d, sel, clr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d, ovf_q, ovf_d, load;
    always_comb begin
        load      = !valid_q || out_ready;
        // x & -x isolates the lowest set bit, giving lowest-index priority
        sel       = pending_q & (~pending_q + N'(1));
        clr       = load ? sel : '0;
        pending_d = (pending_q & ~clr) | req;
        // a bit being loaded this edge is not a collision even if re-requested
        ovf_d     = |(req & pending_q & ~clr);
        onehot_d  = load ? sel : onehot_q;
        valid_d   = load ? |pending_q : valid_q;
        cnt_d     = '0;
        for (int i = 0; i < N; i++) cnt_d = cnt_d + CW'(pending_d[i]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            onehot_q  <= onehot_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end
    assign out_onehot  = onehot_q;
    assign out_valid   = valid_q;
    assign pending     = pending_q;
    assign pending_cnt = cnt_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_onehot_req_serializer.sv
// tb_onehot_req_serializer: vector table plus grant-order scoreboard for onehot_req_serializer
module tb_onehot_req_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b1;
    logic [7:0] out_onehot, pending;
    logic       out_valid, overflow;
    logic [3:0] pending_cnt;
    int         total = 0;
    int         bad = 0;
    bit         sb_on = 1'b0;
    logic [7:0] q[$];

    typedef struct packed {
        logic       rst_n;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] oh;
        logic       v;
        logic [7:0] pend;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;
    vec_t tv[$];

    onehot_req_serializer #(.N(8), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_onehot(out_onehot),
        .out_valid(out_valid), .out_ready(out_ready), .pending(pending),
        .pending_cnt(pending_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // handshake is judged from the values visible just before the edge
    task automatic step();
        logic       hs;
        logic [7:0] g;
        hs = out_valid && out_ready;
        g  = out_onehot;
        @(posedge clk);
        #1;
        chk("inv_onehot", int'($countones(out_onehot) <= 1 && (out_valid || out_onehot == 0)), 1);
        if (sb_on && hs) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra act=%0h exp=none", g);
            end else chk("sb_grant", g, q.pop_front());
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, "_oh"}, out_onehot, e.oh);
        chk({tag, "_v"}, out_valid, e.v);
        chk({tag, "_pend"}, pending, e.pend);
        chk({tag, "_cnt"}, pending_cnt, e.cnt);
        chk({tag, "_ovf"}, overflow, e.ovf);
    endtask

    initial begin
        // reset held with all requests high, then released idle
        for (int i = 0; i < 3; i++) tv.push_back({1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0});
        for (int i = 0; i < 2; i++) tv.push_back({1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0});
        // single request: capture, grant, drain
        tv.push_back({1'b1, 8'h04, 1'b1, 8'h00, 1'b0, 8'h04, 4'd1, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 4'd0, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0});
        // multi-hot burst served in ascending order without bubbles
        tv.push_back({1'b1, 8'h9C, 1'b1, 8'h00, 1'b0, 8'h9C, 4'd4, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h04, 1'b1, 8'h98, 4'd3, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h08, 1'b1, 8'h90, 4'd2, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h10, 1'b1, 8'h80, 4'd1, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h80, 1'b1, 8'h00, 4'd0, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0});
        // overflow while stalled, then re-request of the bit being loaded
        tv.push_back({1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'h01, 4'd1, 1'b0});
        tv.push_back({1'b1, 8'h08, 1'b0, 8'h01, 1'b1, 8'h08, 4'd1, 1'b0});
        tv.push_back({1'b1, 8'h08, 1'b0, 8'h01, 1'b1, 8'h08, 4'd1, 1'b1});
        tv.push_back({1'b1, 8'h00, 1'b0, 8'h01, 1'b1, 8'h08, 4'd1, 1'b0});
        tv.push_back({1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 8'h08, 4'd1, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h08, 1'b1, 8'h00, 4'd0, 1'b0});
        tv.push_back({1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0});
        foreach (tv[i]) begin
            rst_n = tv[i].rst_n;
            req = tv[i].req;
            out_ready = tv[i].rdy;
            step();
            chk_all($sformatf("vec%0d", i), tv[i]);
        end

        // stalled grant must hold while a later request accumulates
        req = 8'h01; out_ready = 1'b0; step();
        req = 8'h00; step();
        chk("stall_first", out_onehot, 8'h01);
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 0) ? 8'h02 : 8'h00;
            step();
            chk("stall_hold_oh", out_onehot, 8'h01);
            chk("stall_hold_v", out_valid, 1);
            chk("stall_pend", pending, 8'h02);
        end
        req = 8'h00; out_ready = 1'b1; step();
        chk("stall_next", out_onehot, 8'h02);
        step();
        chk("stall_drain", out_valid, 0);

        // reset in the middle of a busy burst drops everything
        req = 8'hF1; step();
        req = 8'h00; out_ready = 1'b0; step();
        chk("mid_pend", pending, 8'hF0);
        chk("mid_v", out_valid, 1);
        rst_n = 1'b0; step();
        chk_all("mid_rst", {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0});
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_v", out_valid, 0);
        end

        // scoreboard: random bursts, random backpressure, grants in ascending order
        sb_on = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [7:0] pat;
            int n;
            pat = 8'($urandom_range(1, 255));
            req = pat; out_ready = 1'b0;
            for (int b = 0; b < 8; b++) if (pat[b]) q.push_back(8'(1 << b));
            step();
            chk("sb_cnt", pending_cnt, $countones(pat));
            req = 8'h00;
            n = 0;
            while (q.size() > 0 && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                n++;
            end
            if (q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL sb_timeout left=%0d exp=0", q.size());
                q.delete();
            end
            out_ready = 1'b1;
            step();
            chk("sb_idle_v", out_valid, 0);
            chk("sb_idle_pend", pending, 0);
        end
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/onehot_req_serializer.md
Name: onehot_req_serializer

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures asynchronous-in-time request strobes on N lines into a sticky pending register.
- Presents pending requests one at a time as a guaranteed one-hot (or all-zero) vector with a valid/ready handshake, so the downstream encoder never sees multi-hot input.
- Lowest index has highest priority.

Parameters:
- N, 8, number of request lines and width of the one-hot output (legal range 2..16).
- CW, 4, width of pending_cnt; must hold N (clog2(N+1)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  request strobes, sampled every edge; any bit high for one or more cycles marks that line pending.
- out_onehot  output  N  registered one-hot grant to downstream encoder; all zero when out_valid=0.
- out_valid  output  1  out_onehot holds a valid grant.
- out_ready  input  1  downstream accepts the grant this edge when out_valid=1.
- pending  output  N  registered sticky pending vector (not yet loaded into output).
- pending_cnt  output  CW  popcount of pending, registered, consistent with pending on the same cycle.
- overflow  output  1  one-cycle pulse: a request hit a line already pending.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: on any edge with rst_n=0:
  - pending=0, pending_cnt=0, out_onehot=0, out_valid=0, overflow=0.
  - req is ignored that edge; all in-flight and pending requests are dropped (reset mid-operation included).
- Per edge with rst_n=1, combinational terms from current registers:
  - load = !out_valid | out_ready
  - sel = lowest-index set bit of pending (zero vector if pending=0)
  - clr = load ? sel : 0
- Register updates:
  - if load: out_onehot <= sel; out_valid <= |pending.
  - if !load: out_onehot and out_valid hold, and must stay stable while out_valid=1 and out_ready=0.
  - pending <= (pending & ~clr) | req
  - pending_cnt <= popcount of new pending.
  - overflow <= |(req & pending & ~clr).
- Latency: req bit high before edge k appears in pending after edge k. If the output stage is free at edge k+1, out_valid=1 with that bit after edge k+1 (2 edges req-to-valid).
- Throughput: one grant per cycle with out_ready held high. No bubble between back-to-back grants while pending is nonzero.
- Simultaneous events:
  - req on the bit being loaded this edge: bit stays pending, no overflow; it is served again later.
  - req on the bit currently in out_onehot (not in pending): captured normally, no overflow.
  - Multiple req bits in one cycle: all captured; served in ascending index order.
  - A lower-index request arriving later preempts pending higher ones at the next load, never the in-flight grant.
- Invariants:
  - out_onehot is zero or exactly one-hot.
  - out_onehot & pending == 0 immediately after a load.
  - out_valid=0 implies out_onehot=0.
- Counter: pending_cnt never exceeds N; no wrap.

Test Plan:
1. rst_n=0 for 3 edges with req=8'hFF, out_ready=1 -> all outputs 0 throughout; after release with req=0, out_valid stays 0.
2. req=8'b00000100 for one cycle, out_ready=1 -> after edge1 pending=04, pending_cnt=1; after edge2 out_valid=1, out_onehot=04, pending=0; after edge3 out_valid=0, out_onehot=00.
3. req=8'b10011100 for one cycle, out_ready=1 -> out_onehot 04,08,10,80 on four consecutive cycles; pending_cnt after capture 4, then 3,2,1,0; then out_valid=0.
4. Grant 01 valid, out_ready=0 for 5 cycles while req=8'h02 pulses -> out_onehot holds 01, pending=02; on out_ready=1, the next cycle shows out_onehot=02.
5. pending=08 with output stalled (out_ready=0), req=08 -> overflow=1 for exactly one cycle, pending stays 08, pending_cnt=1. Repeat with the bit being loaded that edge -> overflow=0.
6. pending=F0, out_valid=1, rst_n=0 for one edge -> all registers 0; with req=0 afterward, no out_valid for 10 cycles.
